// File: rtl/mul_unit_pkg.sv
// mul_unit_pkg
//   Shared definitions for the multicycle core's multiply path:
//   - MulOp encodings driven by the controller into mul_unit.
//   - FSM state constants for mul_unit (IDLE / CALC / FIX).
//   - The Instr[7:4] pattern the controller decodes as a multiply.
//   - Small helpers used by the decoder and by mul_unit.
package mul_unit_pkg;

    // MulOp encodings. 2'b01 is reserved and executes as MUL.
    localparam logic [1:0] MUL_OP   = 2'b00;
    localparam logic [1:0] UMULL_OP = 2'b10;
    localparam logic [1:0] SMULL_OP = 2'b11;

    // FSM states.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    // Instr[7:4] value that marks a multiply in the data-processing space.
    localparam logic [3:0] MUL_PATTERN = 4'b1001;

    // True when Instr[7:4] selects the multiply path.
    function automatic logic is_mul_instr(input logic [3:0] instr_7_4);
        return instr_7_4 == MUL_PATTERN;
    endfunction

    // Long ops (UMULL/SMULL) report flags over the full 2*WIDTH product.
    function automatic logic is_long_op(input logic [1:0] mul_op);
        return mul_op[1];
    endfunction

    // Signed ops work on magnitudes and fix the sign at the end.
    function automatic logic is_signed_op(input logic [1:0] mul_op);
        return mul_op == SMULL_OP;
    endfunction

endpackage

// File: rtl/mul_unit_if.sv
// mul_unit_if
//   Controller <-> multiply unit bundle.
//   Handshake: Start is a request that is accepted on a rising edge only
//   while Busy is low (unit in IDLE); a Start seen while Busy is high is
//   dropped, never queued. Done is a one-cycle valid pulse with no
//   backpressure; ResultLo/ResultHi/FlagsNZ are valid with Done and held
//   until the next completed operation. Flush cancels any operation in
//   flight and has priority over Start.
//   Signals:
//     Start, MulOp[1:0], SrcA, SrcB, Flush   controller -> unit
//     Busy, Done, ResultLo, ResultHi,        unit -> controller
//     FlagsNZ[1:0], dbg_state[1:0]
//   dbg_state mirrors the unit's FSM state for observation only.
interface mul_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       MulOp;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             Flush;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] ResultLo;
    logic [WIDTH-1:0] ResultHi;
    logic [1:0]       FlagsNZ;
    logic [1:0]       dbg_state;

    modport master (
        output Start, MulOp, SrcA, SrcB, Flush,
        input  Busy, Done, ResultLo, ResultHi, FlagsNZ, dbg_state
    );

    modport slave (
        input  Start, MulOp, SrcA, SrcB, Flush,
        output Busy, Done, ResultLo, ResultHi, FlagsNZ, dbg_state
    );
endinterface

// File: rtl/mul_unit.sv
// mul_unit
//   Iterative radix-2 shift-add multiplier for MUL, UMULL and SMULL.
//   One product takes WIDTH CALC cycles plus one FIX cycle; Done pulses in
//   the cycle after FIX, when the unit is already back in IDLE.
//   Ports:
//     clk    core clock, rising edge
//     reset  asynchronous active-low reset
//     bus    mul_unit_if slave modport (Start/MulOp/SrcA/SrcB/Flush in,
//            Busy/Done/ResultLo/ResultHi/FlagsNZ/dbg_state out)
//   All outputs come straight from registers or from a decode of the state
//   register, so there is no input-to-output combinational path.
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    mul_unit_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic [1:0]         state_q,    state_d;
    logic [CW-1:0]      count_q,    count_d;
    logic [1:0]         op_q,       op_d;
    logic               neg_q,      neg_d;
    logic [WIDTH-1:0]   mcand_q,    mcand_d;
    logic [WIDTH-1:0]   mplier_q,   mplier_d;
    logic [2*WIDTH-1:0] acc_q,      acc_d;
    logic [WIDTH-1:0]   res_lo_q,   res_lo_d;
    logic [WIDTH-1:0]   res_hi_q,   res_hi_d;
    logic [1:0]         flags_q,    flags_d;
    logic               done_q,     done_d;

    // Datapath helpers.
    logic [WIDTH-1:0]   src_a_abs;
    logic [WIDTH-1:0]   src_b_abs;
    logic [WIDTH:0]     partial_sum;
    logic [2*WIDTH-1:0] product;
    logic               flag_n;
    logic               flag_z;

    // Magnitudes for SMULL. The most-negative value negates to itself,
    // which read as unsigned is exactly its magnitude.
    assign src_a_abs = bus.SrcA[WIDTH-1] ? (~bus.SrcA + WIDTH'(1)) : bus.SrcA;
    assign src_b_abs = bus.SrcB[WIDTH-1] ? (~bus.SrcB + WIDTH'(1)) : bus.SrcB;

    // Add the multiplicand into the upper half, keeping the carry so the
    // following right shift does not lose it.
    assign partial_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                       + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};

    assign product = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

    always_comb begin
        flag_n = 1'b0;
        flag_z = 1'b0;
        if (is_long_op(op_q)) begin
            flag_n = product[2*WIDTH-1];
            flag_z = (product == {2*WIDTH{1'b0}});
        end else begin
            flag_n = product[WIDTH-1];
            flag_z = (product[WIDTH-1:0] == {WIDTH{1'b0}});
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        flags_d  = flags_q;
        done_d   = 1'b0;

        if (bus.Flush) begin
            // Abort wins over everything, including a Start in IDLE and the
            // result write in FIX.
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        op_d    = bus.MulOp;
                        acc_d   = '0;
                        count_d = '0;
                        if (is_signed_op(bus.MulOp)) begin
                            mcand_d  = src_a_abs;
                            mplier_d = src_b_abs;
                            neg_d    = bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1];
                        end else begin
                            mcand_d  = bus.SrcA;
                            mplier_d = bus.SrcB;
                            neg_d    = 1'b0;
                        end
                        state_d = CALC;
                    end
                end
                CALC: begin
                    acc_d    = {partial_sum, acc_q[WIDTH-1:1]};
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CW'(1);
                    if (count_q == LAST_COUNT) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    res_lo_d = product[WIDTH-1:0];
                    res_hi_d = product[2*WIDTH-1:WIDTH];
                    flags_d  = {flag_n, flag_z};
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= MUL_OP;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            flags_q  <= 2'b00;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign bus.Busy      = (state_q != IDLE);
    assign bus.Done      = done_q;
    assign bus.ResultLo  = res_lo_q;
    assign bus.ResultHi  = res_hi_q;
    assign bus.FlagsNZ   = flags_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit
//   Self-checking bench for mul_unit: directed vectors, randomized
//   operations against an arithmetic reference model, Start contention,
//   back-to-back issue, Flush aborts and asynchronous reset mid-operation.
module tb_mul_unit;
    import mul_unit_pkg::*;

    localparam int W = 32;
    // Drive-to-Done distance counted in falling edges: Start is sampled at
    // edge k, Done is visible after edge k+W+1.
    localparam int DONE_LAT = W + 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [2*W+1:0] exp_q[$];

    mul_unit_if #(.WIDTH(W)) bus ();

    mul_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Returns {N, Z, hi, lo} computed with plain wide arithmetic.
    function automatic logic [2*W+1:0] model(input logic [1:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic n, z;
        if (op == 2'b11)
            p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        else
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        if (op[1]) begin
            n = p[2*W-1];
            z = (p == 0);
        end else begin
            n = p[W-1];
            z = (p[W-1:0] == 0);
        end
        return {n, z, p};
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge; Start is sampled on the next rising edge.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        bus.Start = 1'b1;
        bus.MulOp = op;
        bus.SrcA  = a;
        bus.SrcB  = b;
        exp_q.push_back(model(op, a, b));
    endtask

    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (1) begin
            @(negedge clk);
            bus.Start = 1'b0;
            lat++;
            if (bus.Busy) busy_cnt++;
            if (bus.Done) break;
            if (lat >= 100) break;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset     = 1'b0;
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        bus.MulOp = 2'b00;
        bus.SrcA  = '0;
        bus.SrcB  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.Busy, bus.Done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_busy_done: got %b expected 00", {bus.Busy, bus.Done});
        end
        checks++;
        if ({bus.FlagsNZ, bus.ResultHi, bus.ResultLo} !== '0) begin
            errors++;
            $display("FAIL reset_results: got %h/%h/%b expected zeros",
                     bus.ResultHi, bus.ResultLo, bus.FlagsNZ);
        end
        checks++;
        if (bus.dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, IDLE);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [1:0]   ops [7] = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b01};
        logic [W-1:0] as  [7] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000000,
                                  32'h00010000, 32'd0, 32'd3};
        logic [W-1:0] bs  [7] = '{32'd6, 32'hFFFFFFFF, 32'd3, 32'h80000000,
                                  32'h00010000, 32'hFFFFFFFB, 32'd5};
        logic [W-1:0] los [7] = '{32'h2A, 32'h1, 32'hFFFFFFFA, 32'h0, 32'h0, 32'h0, 32'hF};
        logic [W-1:0] his [7] = '{32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000,
                                  32'h1, 32'h0, 32'h0};
        logic [1:0]   nzs [7] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
        int lat, busy_cnt;
        logic [2*W+1:0] dummy;
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(lat, busy_cnt);
            dummy = exp_q.pop_front();
            checks++;
            if (lat !== DONE_LAT || busy_cnt !== W + 1) begin
                errors++;
                $display("FAIL directed_%0d_timing: got lat %0d busy %0d expected lat %0d busy %0d",
                         i, lat, busy_cnt, DONE_LAT, W + 1);
            end
            checks++;
            if ({bus.FlagsNZ, bus.ResultHi, bus.ResultLo} !== {nzs[i], his[i], los[i]}) begin
                errors++;
                $display("FAIL directed_%0d_result: got %b %h %h expected %b %h %h", i,
                         bus.FlagsNZ, bus.ResultHi, bus.ResultLo, nzs[i], his[i], los[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat, busy_cnt;
        logic [2*W+1:0] exp;
        logic [W-1:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom();
            b = $urandom();
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            if ($urandom_range(0, 5) == 0) b = $urandom_range(0, 3);
            issue(2'($urandom_range(0, 3)), a, b);
            wait_done(lat, busy_cnt);
            exp = exp_q.pop_front();
            checks++;
            if (lat !== DONE_LAT || {bus.FlagsNZ, bus.ResultHi, bus.ResultLo} !== exp) begin
                errors++;
                $display("FAIL random_%0d: got lat %0d %b %h %h expected lat %0d %b %h %h", i,
                         lat, bus.FlagsNZ, bus.ResultHi, bus.ResultLo, DONE_LAT,
                         exp[2*W+1:2*W], exp[2*W-1:W], exp[W-1:0]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int done_cnt = 0;
        logic [2*W+1:0] exp;
        issue(2'b10, 32'h12345678, 32'h9ABCDEF0);
        exp = exp_q.pop_front();
        for (int lat = 1; lat <= 80; lat++) begin
            @(negedge clk);
            bus.Start = 1'b0;
            if (lat == 5) begin
                bus.Start = 1'b1;
                bus.MulOp = 2'b00;
                bus.SrcA  = 32'd3;
                bus.SrcB  = 32'd3;
            end
            if (bus.Done) begin
                done_cnt++;
                checks++;
                if (lat !== DONE_LAT || {bus.FlagsNZ, bus.ResultHi, bus.ResultLo} !== exp) begin
                    errors++;
                    $display("FAIL busy_start_result: got lat %0d %b %h %h expected lat %0d %h",
                             lat, bus.FlagsNZ, bus.ResultHi, bus.ResultLo, DONE_LAT, exp);
                end
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL busy_start_done_count: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int lat, busy_cnt;
        logic [2*W+1:0] exp;
        @(negedge clk);
        issue(2'b11, 32'hFFFFFF00, 32'h00001234);
        wait_done(lat, busy_cnt);
        exp = exp_q.pop_front();
        checks++;
        if ({bus.FlagsNZ, bus.ResultHi, bus.ResultLo} !== exp) begin
            errors++;
            $display("FAIL b2b_first: got %b %h %h expected %h",
                     bus.FlagsNZ, bus.ResultHi, bus.ResultLo, exp);
        end
        // Still in the Done cycle: this Start must be accepted.
        issue(2'b00, 32'hDEADBEEF, 32'h00000010);
        wait_done(lat, busy_cnt);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== DONE_LAT || {bus.FlagsNZ, bus.ResultHi, bus.ResultLo} !== exp) begin
            errors++;
            $display("FAIL b2b_second: got lat %0d %b %h %h expected lat %0d %h",
                     lat, bus.FlagsNZ, bus.ResultHi, bus.ResultLo, DONE_LAT, exp);
        end
    endtask

    task automatic test_flush();
        int lat, busy_cnt, done_cnt;
        logic [2*W+1:0] prior, dummy;
        @(negedge clk);
        issue(2'b00, 32'd7, 32'd6);
        wait_done(lat, busy_cnt);
        prior = exp_q.pop_front();
        checks++;
        if ({bus.FlagsNZ, bus.ResultHi, bus.ResultLo} !== prior) begin
            errors++;
            $display("FAIL flush_setup: got %h %h expected %h", bus.ResultHi, bus.ResultLo, prior);
        end

        // Flush mid-CALC (rising edge k+10).
        @(negedge clk);
        issue(2'b10, $urandom(), $urandom());
        dummy = exp_q.pop_back();
        done_cnt = 0;
        for (lat = 1; lat <= 50; lat++) begin
            @(negedge clk);
            bus.Start = 1'b0;
            bus.Flush = (lat == 10);
            if (lat == 11) begin
                checks++;
                if (bus.Busy !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_calc_busy: got %b expected 0", bus.Busy);
                end
            end
            if (bus.Done) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0 || {bus.FlagsNZ, bus.ResultHi, bus.ResultLo} !== prior) begin
            errors++;
            $display("FAIL flush_calc_hold: got dones %0d %b %h %h expected 0 %h",
                     done_cnt, bus.FlagsNZ, bus.ResultHi, bus.ResultLo, prior);
        end

        // Flush on the FIX edge (rising edge k+W+1).
        issue(2'b11, 32'hFFFFFFFF, 32'd1);
        dummy = exp_q.pop_back();
        done_cnt = 0;
        for (lat = 1; lat <= 50; lat++) begin
            @(negedge clk);
            bus.Start = 1'b0;
            bus.Flush = (lat == W + 1);
            if (bus.Done) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0 || bus.Busy !== 1'b0 ||
            {bus.FlagsNZ, bus.ResultHi, bus.ResultLo} !== prior) begin
            errors++;
            $display("FAIL flush_fix: got dones %0d busy %b %b %h %h expected 0 0 %h",
                     done_cnt, bus.Busy, bus.FlagsNZ, bus.ResultHi, bus.ResultLo, prior);
        end

        // Flush and Start together in IDLE: no capture.
        bus.Start = 1'b1;
        bus.Flush = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        checks++;
        if (bus.Busy !== 1'b0 || bus.dbg_state !== IDLE) begin
            errors++;
            $display("FAIL flush_start_same: got busy %b state %0d expected 0 %0d",
                     bus.Busy, bus.dbg_state, IDLE);
        end
    endtask

    task automatic test_reset_mid();
        int lat, busy_cnt;
        logic [2*W+1:0] exp, dummy;
        @(negedge clk);
        issue(2'b10, 32'hCAFEF00D, 32'h0BADBEEF);
        dummy = exp_q.pop_back();
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus.Start = 1'b0;
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.Busy, bus.Done, bus.FlagsNZ, bus.ResultHi, bus.ResultLo} !== '0 ||
            bus.dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_mid_clear: got busy %b done %b %b %h %h state %0d expected zeros",
                     bus.Busy, bus.Done, bus.FlagsNZ, bus.ResultHi, bus.ResultLo, bus.dbg_state);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(2'b00, 32'd1000, 32'd1000);
        wait_done(lat, busy_cnt);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== DONE_LAT || {bus.FlagsNZ, bus.ResultHi, bus.ResultLo} !== exp) begin
            errors++;
            $display("FAIL reset_mid_after: got lat %0d %b %h %h expected lat %0d %h",
                     lat, bus.FlagsNZ, bus.ResultHi, bus.ResultLo, DONE_LAT, exp);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
